// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD game timer: tick-enabled up/down counter with load, pause/resume
// and a run FSM that stops at the terminal count.
module bcd_countdown_timer #(
  parameter int unsigned TENS_MAX   = 5,
  parameter int unsigned START_TENS = 5,
  parameter int unsigned START_ONES = 9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       up,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] TMAX  = DW'(TENS_MAX);
  localparam logic [DW-1:0] OMAX  = DW'(9);
  localparam logic [DW-1:0] TINIT = DW'(START_TENS);
  localparam logic [DW-1:0] OINIT = DW'(START_ONES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   tens_q, tens_d;
  logic [DW-1:0]   ones_q, ones_d;
  logic            dir_up_q, dir_up_d;
  logic            running_q, running_d;
  logic            expired_q, expired_d;
  logic            done_q, done_d;
  logic [DW-1:0]   step_tens_c, step_ones_c;

  // Terminal count is 00 counting down and {TENS_MAX,9} counting up.
  function automatic logic at_terminal(input logic dir_up, input logic [DW-1:0] t,
                                       input logic [DW-1:0] o);
    if (dir_up) at_terminal = (t == TMAX) && (o == OMAX);
    else        at_terminal = (t == '0) && (o == '0);
  endfunction

  // One count step in the latched direction; only used when not at terminal.
  always_comb begin
    step_tens_c = tens_q;
    step_ones_c = ones_q;
    if (dir_up_q) begin
      if (ones_q == OMAX) begin
        step_ones_c = '0;
        step_tens_c = tens_q + DW'(1);
      end else begin
        step_ones_c = ones_q + DW'(1);
      end
    end else begin
      if (ones_q == '0) begin
        step_ones_c = OMAX;
        step_tens_c = tens_q - DW'(1);
      end else begin
        step_ones_c = ones_q - DW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    dir_up_d = dir_up_q;
    if (load) begin
      tens_d  = (load_tens > TMAX) ? TMAX : load_tens;
      ones_d  = (load_ones > OMAX) ? OMAX : load_ones;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!pause && start) begin
            dir_up_d = up;
            state_d  = at_terminal(up, tens_q, ones_q) ? EXPIRED : RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick && !at_terminal(dir_up_q, tens_q, ones_q)) begin
            tens_d = step_tens_c;
            ones_d = step_ones_c;
            if (at_terminal(dir_up_q, step_tens_c, step_ones_c)) state_d = EXPIRED;
          end
        end
        PAUSED: begin
          if (!pause && start) state_d = RUN;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
    done_d    = (state_d == EXPIRED) && (state_q != EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      tens_q    <= TINIT;
      ones_q    <= OINIT;
      dir_up_q  <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      dir_up_q  <= dir_up_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: per-cycle expected outputs are queued
// when the stimulus is applied and checked after the following clock edge.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       clr = 1'b0, tick = 1'b0, start = 1'b0, pause = 1'b0, load = 1'b0, up = 1'b0;
  logic [3:0] load_tens = '0, load_ones = '0;
  logic [3:0] tens, ones;
  logic       running, expired, done;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [10:0] exp_q[$];

  bcd_countdown_timer #(.TENS_MAX(5), .START_TENS(5), .START_ONES(9)) dut (
    .clk(clk), .clr(clr), .tick(tick), .start(start), .pause(pause), .load(load),
    .load_tens(load_tens), .load_ones(load_ones), .up(up),
    .tens(tens), .ones(ones), .running(running), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs, queue the expected post-edge outputs, then check.
  task automatic cyc(input logic c, input logic l, input logic p, input logic s,
                     input logic t, input logic u, input logic [3:0] lt,
                     input logic [3:0] lo, input logic [3:0] et, input logic [3:0] eo,
                     input logic er, input logic ee, input logic ed, input string tag);
    logic [10:0] e, o;
    clr = c; load = l; pause = p; start = s; tick = t; up = u;
    load_tens = lt; load_ones = lo;
    exp_q.push_back({et, eo, er, ee, ed});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {tens, ones, running, expired, done};
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got t=%0d o=%0d run=%b exp=%b done=%b, want t=%0d o=%0d run=%b exp=%b done=%b",
                tag, o[10:7], o[6:3], o[2], o[1], o[0], e[10:7], e[6:3], e[2], e[1], e[0]);
    clr = 1'b0; load = 1'b0; pause = 1'b0; start = 1'b0; tick = 1'b0;
  endtask

  initial begin
    int v;
    @(negedge clk);
    // 1: full countdown from reset
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 5, 9, 0, 0, 0, "reset");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 5, 9, 1, 0, 0, "t1_start");
    for (int i = 1; i <= 59; i++) begin
      v = 59 - i;
      cyc(0, 0, 0, 0, 1, 0, 0, 0, 4'(v / 10), 4'(v % 10), v != 0, v == 0, v == 0, "t1_tick");
    end
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "t1_hold00");
    // 2: loads and tens borrow
    cyc(0, 1, 0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, "t2_load30");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 1, 0, 0, "t2_start");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 2, 9, 1, 0, 0, "t2_tick29");
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, "t2_load10");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, "t2_start2");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 9, 1, 0, 0, "t2_borrow09");
    // 3: pause/resume
    cyc(0, 1, 0, 0, 0, 0, 4, 5, 4, 5, 0, 0, 0, "t3_load45");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 4, 5, 1, 0, 0, "t3_start");
    cyc(0, 0, 1, 0, 1, 0, 0, 0, 4, 5, 0, 0, 0, "t3_pause_tick");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0, 4, 5, 0, 0, 0, "t3_paused_tick");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 4, 5, 0, 0, 0, "t3_repause");
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 4, 5, 1, 0, 0, "t3_resume");
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 4, 4, 1, 0, 0, "t3_tick44");
    // 4: clamping, exit from EXPIRED via load
    cyc(0, 1, 0, 0, 0, 0, 9, 12, 5, 9, 0, 0, 0, "t4_clamp");
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "t4_load01");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, "t4_start");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, "t4_expire");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "t4_done_once");
    cyc(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, "t4_ignore");
    cyc(0, 1, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, "t4_load20");
    // 5: count up to {5,9}; up change mid-run ignored
    cyc(0, 1, 0, 0, 0, 0, 5, 7, 5, 7, 0, 0, 0, "t5_load57");
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 5, 7, 1, 0, 0, "t5_start_up");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 5, 8, 1, 0, 0, "t5_tick58");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 5, 9, 0, 1, 1, "t5_tick59");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 5, 9, 0, 1, 0, "t5_hold59");
    // 6: clr mid-run, early-start expiry
    cyc(0, 1, 0, 0, 0, 0, 3, 2, 3, 2, 0, 0, 0, "t6_load32");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 3, 2, 1, 0, 0, "t6_start");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 3, 1, 1, 0, 0, "t6_tick31");
    cyc(1, 1, 0, 1, 1, 0, 2, 2, 5, 9, 0, 0, 0, "t6_clr");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 5, 9, 0, 0, 0, "t6_idle_tick");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t6_load00");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "t6_early_expire");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "t6_done_once");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
